// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe
// Pipelined, recursively split approximate unsigned multiplier with a
// valid/ready stream interface.
//
// Each operand is split into a high part [W-1:S] and a low part [S-1:0].
// Stage 1 forms the four exact sub-products. Stage 2 adds the two cross
// products. Stage 3 merges the cross sum into {P1, P4 high half}. Both
// adders can OR their low K bits instead of adding them, selected per beat
// by the mode bit that travels with the data.
//
// All stages advance together (adv = !out_valid | out_ready), so a stalled
// output freezes the whole pipe and bubbles are kept.
//
// Optional feature macro: APPROX_MULT_ERR_STAT_EN
//   When defined, an exact shadow product rides along with each beat. Every
//   delivered beat whose result differs from it bumps err_count (saturating)
//   and updates err_max with the largest absolute error seen. stat_clr is a
//   synchronous clear that wins over a same-cycle update.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    input handshake
//   in_a, in_b [W]       unsigned operands
//   in_approx            1 = approximate adders, 0 = exact product
//   in_tag [TAG_W]       sideband tag, returned unchanged with the result
//   out_valid/out_ready  output handshake
//   out_p [2W]           product
//   out_tag [TAG_W]      tag of the result
//   stat_clr, err_count [32], err_max [2W]  (feature build only)
module approx_mult_pipe #(
    parameter int W     = 8,
    parameter int S     = 2,
    parameter int K     = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_approx,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_p,
    output logic [TAG_W-1:0] out_tag
`ifdef APPROX_MULT_ERR_STAT_EN
    ,
    input  logic             stat_clr,
    output logic [31:0]      err_count,
    output logic [2*W-1:0]   err_max
`endif
);

    localparam int HW = W - S;          // high-part width
    localparam int UW = 2 * W - S;      // width of the final adder
    // Approximated span of each adder, never wider than the adder itself.
    localparam int KX = (K > W)  ? W  : K;
    localparam int KO = (K > UW) ? UW : K;
    // Masks selecting the OR-approximated low bits of each adder.
    localparam logic [W:0]    MASK_X = ~({(W + 1){1'b1}} << KX);
    localparam logic [UW-1:0] MASK_O = ~({UW{1'b1}} << KO);

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ---------------- stage 1: four exact sub-products ----------------
    logic [2*HW-1:0] p1_c;
    logic [W-1:0]    p2_c, p3_c;
    logic [2*S-1:0]  p4_c;

    assign p1_c = in_a[W-1:S] * in_b[W-1:S];
    assign p2_c = in_a[W-1:S] * in_b[S-1:0];
    assign p3_c = in_a[S-1:0] * in_b[W-1:S];
    assign p4_c = in_a[S-1:0] * in_b[S-1:0];

    logic             s1_valid, s1_approx;
    logic [TAG_W-1:0] s1_tag;
    logic [2*HW-1:0]  s1_p1;
    logic [W-1:0]     s1_p2, s1_p3;
    logic [2*S-1:0]   s1_p4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_approx <= 1'b0;
            s1_tag    <= '0;
            s1_p1     <= '0;
            s1_p2     <= '0;
            s1_p3     <= '0;
            s1_p4     <= '0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s1_approx <= in_approx;
            s1_tag    <= in_tag;
            s1_p1     <= p1_c;
            s1_p2     <= p2_c;
            s1_p3     <= p3_c;
            s1_p4     <= p4_c;
        end
    end

    // ---------------- stage 2: cross sum X = P2 (+) P3 ----------------
    logic [W:0] xa, xb, x_exact, x_approx, x_c;

    assign xa       = {1'b0, s1_p2};
    assign xb       = {1'b0, s1_p3};
    assign x_exact  = xa + xb;
    // With the low bits masked off the upper add receives no carry from them.
    assign x_approx = ((xa | xb) & MASK_X) | ((xa & ~MASK_X) + (xb & ~MASK_X));
    assign x_c      = s1_approx ? x_approx : x_exact;

    logic             s2_valid, s2_approx;
    logic [TAG_W-1:0] s2_tag;
    logic [2*HW-1:0]  s2_p1;
    logic [2*S-1:0]   s2_p4;
    logic [W:0]       s2_x;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_approx <= 1'b0;
            s2_tag    <= '0;
            s2_p1     <= '0;
            s2_p4     <= '0;
            s2_x      <= '0;
        end else if (adv) begin
            s2_valid  <= s1_valid;
            s2_approx <= s1_approx;
            s2_tag    <= s1_tag;
            s2_p1     <= s1_p1;
            s2_p4     <= s1_p4;
            s2_x      <= x_c;
        end
    end

    // ---------------- stage 3: O = {P1, P4 high} (+) X ----------------
    logic [UW-1:0]  u, ox, o_exact, o_approx, o_c;
    logic [2*W-1:0] p_c;

    assign u        = {s2_p1, s2_p4[2*S-1:S]};
    assign ox       = UW'(s2_x);
    assign o_exact  = u + ox;
    assign o_approx = ((u | ox) & MASK_O) | ((u & ~MASK_O) + (ox & ~MASK_O));
    assign o_c      = s2_approx ? o_approx : o_exact;
    assign p_c      = {o_c, s2_p4[S-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_tag   <= '0;
            out_p     <= '0;
        end else if (adv) begin
            out_valid <= s2_valid;
            out_tag   <= s2_tag;
            out_p     <= p_c;
        end
    end

`ifdef APPROX_MULT_ERR_STAT_EN
    // Exact shadow product travelling alongside the datapath.
    logic [2*W-1:0] s1_exact, s2_exact, s3_exact, err_abs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_exact <= '0;
            s2_exact <= '0;
            s3_exact <= '0;
        end else if (adv) begin
            s1_exact <= in_a * in_b;
            s2_exact <= s1_exact;
            s3_exact <= s2_exact;
        end
    end

    assign err_abs = (s3_exact >= out_p) ? (s3_exact - out_p) : (out_p - s3_exact);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
            err_max   <= '0;
        end else if (stat_clr) begin
            err_count <= '0;
            err_max   <= '0;
        end else if (out_valid && out_ready && (out_p != s3_exact)) begin
            if (err_count != 32'hFFFF_FFFF) begin
                err_count <= err_count + 32'd1;
            end
            if (err_abs > err_max) begin
                err_max <= err_abs;
            end
        end
    end
`endif

endmodule

// File: doc/approx_mult_pipe.md
# approx_mult_pipe

A parametrised, pipelined, recursively split approximate unsigned multiplier with a valid/ready stream interface. Each operand is split into high and low parts, four sub-products are formed, and the results are combined by two adders whose low bits can be OR-approximated under a per-transaction mode bit. It sits in the approximate-arithmetic datapath library as the clocked successor to the fixed 8-bit combinational split multipliers, for use in streaming accelerators and NSGA-II design-space sweeps.

## Interface
Parameters:
- `W`, 8: operand width; even, 4..16.
- `S`, 2: low-part split width; 1..W/2.
- `K`, 4: approximated low bits in each adder; 0..W-1 (0 = always exact).
- `TAG_W`, 4: sideband tag width, passed through unchanged; ≥1.

Ports:
- `clk` in 1: clock; one clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block can accept a beat.
- `in_a`, `in_b` in W: unsigned operands.
- `in_approx` in 1: 1 = approximate adders, 0 = exact.
- `in_tag` in TAG_W: sideband tag.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts.
- `out_p` out 2W: product.
- `out_tag` out TAG_W: tag of the result.
- `stat_clr`, `err_count` (32), `err_max` (2W): present only with `APPROX_MULT_ERR_STAT_EN`.

## Operation
- Split: AH=A[W-1:S], AL=A[S-1:0]; BH and BL likewise.
- Stage 1: P1=AH·BH (2(W-S) bits), P2=AH·BL (W), P3=AL·BH (W), P4=AL·BL (2S). All exact.
- Stage 2: cross sum X=P2⊕P3 (W+1 bits).
- Stage 3: U={P1, P4[2S-1:S]} (2W-S bits). O=U⊕X, truncated to 2W-S bits. out_p={O, P4[S-1:0]}.
- ⊕ in approximate mode: bits [K-1:0] = a|b. No carry into bit K. Bits ≥K are an exact add. K is clamped to the operand width. In exact mode ⊕ is +.
- Exact mode must equal A·B for all inputs.
- `in_approx` and `in_tag` travel with their data through every stage.

## Timing
- Three pipeline registers. Latency is 3 cycles from the accept edge to `out_valid`. Throughput is 1 beat/cycle.
- Global stall: adv = !out_valid | out_ready, and in_ready = adv. All stages shift only when adv=1.
- Bubbles do not compress.
- A beat is accepted on in_valid & in_ready. A beat is delivered on out_valid & out_ready.
- While out_valid=1 and out_ready=0: out_p, out_tag and out_valid are held stable.
- Reset (asynchronous):
  - All stage valids are 0; out_valid=0; out_p=0; out_tag=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - err_count=0; err_max=0.
- Reset mid-operation discards all in-flight beats. No partial result is emitted.
- Inputs are ignored when in_valid=0. Data registers may hold stale values; only the valid bits matter.

## Configuration
`APPROX_MULT_ERR_STAT_EN`:
- Defined:
  - An exact shadow product A·B is pipelined alongside the data.
  - On each delivered beat where out_p ≠ exact, err_count increments, saturating at 2^32-1.
  - err_max is updated to max(err_max, |exact−out_p|).
  - stat_clr is synchronous. It zeroes both stats; a clear wins over an update in the same cycle.
- Undefined: the stat ports and logic are absent. Datapath behaviour is identical in both builds.

## Test plan
All tests use W=8, S=2, K=4.
- Exact mode: A=255, B=255, tag=5 → out_p=65025, out_tag=5, 3 cycles after accept.
- Approximate mode: A=255, B=255 → out_p=64957. With stats enabled: err_count=1, err_max=68.
- Approximate mode, error-free cases: A=1, B=1 → 1; A=0, B=200 → 0. err_count is unchanged.
- Back-pressure: stream 6 beats, out_ready=0 for cycles 4–7.
  - in_ready drops while out_valid=1 and out_ready=0.
  - Outputs are held stable during the stall.
  - All 6 results are delivered in order, with no loss or duplication.
- Reset mid-stream: assert rst with 3 beats in flight.
  - out_valid=0 immediately.
  - After release, no stale result appears.
  - A new beat A=3, B=7 → 21.
- Exhaustive exact-mode sweep over all 65536 pairs at full throughput → out_p=A·B every beat. Run as a random sweep for W=16.
